issue_queue_ctrl: RTL
=====================

ISSUE_QUEUE_CTRL -- requirements
Module: issue_queue_ctrl

Interface
REQ-001 Parameter: DEPTH, 8, number of instruction entries; power of two, 2..16.
REQ-002 Parameter: PTR_W, 3, pointer width; SHALL equal log2(DEPTH).
REQ-003 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: rdy  input  1  global ready; when low, all state SHALL hold.
REQ-006 Port: IF_success  input  1  fetch unit presents a valid instruction this cycle.
REQ-007 Port: instr  input  32  fetched instruction word.
REQ-008 Port: pc  input  32  address of instr.
REQ-009 Port: stall_RS  input  1  decoder/RS cannot accept an instruction this cycle.
REQ-010 Port: flush  input  1  misprediction redirect; discard all queued instructions.
REQ-011 Port: IF_stall  output  1  queue full; fetch SHALL NOT present an instruction.
REQ-012 Port: issue_valid  output  1  head entry valid toward the decoder.
REQ-013 Port: issue_instr  output  32  head instruction word.
REQ-014 Port: issue_pc  output  32  head instruction PC.
REQ-015 Port: count  output  PTR_W+1  number of occupied entries, 0..DEPTH.
REQ-016 Port: overflow  output  1  sticky flag: push attempted while full.

Function
REQ-017 Storage SHALL be a circular buffer of DEPTH {instr, pc} entries with head/tail pointers wrapping modulo DEPTH.
REQ-018 Push condition: rdy & IF_success & !full & state==NORMAL & !flush; writes entry at tail, tail+1.
REQ-019 Pop condition: rdy & issue_valid & !stall_RS & !flush; head+1.
REQ-020 Push and pop in the same cycle SHALL leave count unchanged; allowed at any occupancy, including full (pop frees the slot, push is still rejected because full is evaluated pre-edge).
REQ-021 issue_valid SHALL be (count != 0) & state==NORMAL; issue_instr/issue_pc SHALL be the head entry, driven from registered storage (no combinational path from instr/pc).
REQ-022 Latency: instruction pushed at edge N SHALL appear on issue_* after edge N, i.e. one cycle after IF_success into an empty queue.
REQ-023 IF_stall SHALL equal (count == DEPTH).
REQ-024 IF_success while full SHALL be dropped and SHALL set overflow; overflow clears only on rst.
REQ-025 States: NORMAL, DRAIN.
REQ-026 NORMAL -> DRAIN when rdy & flush: head, tail, count SHALL clear to 0 at that edge; push and pop SHALL be suppressed that cycle.
REQ-027 DRAIN SHALL last exactly one rdy-high cycle; IF_success is ignored (stale fetch in flight), not counted as overflow; issue_valid=0; then -> NORMAL.
REQ-028 flush asserted while in DRAIN SHALL keep state DRAIN for one more cycle and keep the queue empty.
REQ-029 flush SHALL take priority over push and pop in every state.
REQ-030 rdy low SHALL freeze pointers, count, state, overflow and storage; outputs keep reflecting frozen state.

Reset
REQ-031 On rst at a rising edge (regardless of rdy): head=0, tail=0, count=0, state=NORMAL, overflow=0; issue_valid=0, IF_stall=0.
REQ-032 rst SHALL override flush, push and pop in the same cycle; storage contents need not be cleared.
REQ-033 rst asserted mid-operation SHALL discard all entries; first push after rst release lands in entry 0.

Verification
REQ-034 Empty, push instr=0x00500093 pc=0x0 with stall_RS=0 -> next cycle issue_valid=1, issue_instr=0x00500093, issue_pc=0x0; following cycle count=0, issue_valid=0.
REQ-035 stall_RS=1, push 8 instructions pc=0x0..0x1C -> count=8, IF_stall=1; 9th IF_success -> dropped, overflow=1, count=8; release stall -> issue_pc 0x0..0x1C in order, one per cycle.
REQ-036 Full queue, IF_success=1 and pop same cycle -> count 7, IF_stall=0 next cycle, pushed word not stored, overflow=1.
REQ-037 count=5, flush=1 with IF_success=1 -> count=0, state DRAIN; next-cycle IF_success ignored (count stays 0, overflow unchanged); third cycle push accepted, issue_valid=1 one cycle later.
REQ-038 Push/pop steady stream of 20 instructions with stall_RS toggling every 3 cycles -> pointers wrap, output order equals input order, no loss, count never exceeds 8.
REQ-039 count=3, rdy=0 for 4 cycles with IF_success=1, stall_RS=0, flush=1 -> no state change; rdy=1 -> behaviour resumes from count=3.

Source files
------------

// File: rtl/issue_queue_ctrl.sv
// Instruction issue queue between fetch and decode/RS.
// Circular buffer of {instr, pc} entries with a two-state flush controller.
// NORMAL accepts and issues. DRAIN lasts one ready cycle after a flush
// so that a stale fetch still in flight is discarded.
module issue_queue_ctrl #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              IF_success,
  input  logic [31:0]       instr,
  input  logic [31:0]       pc,
  input  logic              stall_RS,
  input  logic              flush,
  output logic              IF_stall,
  output logic              issue_valid,
  output logic [31:0]       issue_instr,
  output logic [31:0]       issue_pc,
  output logic [PTR_W:0]    count,
  output logic              overflow
);

  typedef enum logic {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } state_t;

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  state_t           state, state_next;
  logic [PTR_W-1:0] head, tail;
  logic [31:0]      instr_mem [DEPTH];
  logic [31:0]      pc_mem    [DEPTH];
  logic             full, push, pop;

  // Fullness is evaluated on the pre-edge count.
  // A simultaneous pop therefore never lets a push into a full queue.
  assign full        = (count == CNT_FULL);
  assign IF_stall    = full;
  assign issue_valid = (count != '0) && (state == NORMAL);
  assign issue_instr = instr_mem[head];
  assign issue_pc    = pc_mem[head];

  // Flush has priority over push and pop.
  // DRAIN blocks pushes, and issue_valid is low in DRAIN, which blocks pops.
  assign push = rdy && IF_success && !full && (state == NORMAL) && !flush;
  assign pop  = rdy && issue_valid && !stall_RS && !flush;

  // Next-state logic: flush enters or extends DRAIN; DRAIN otherwise lasts one ready cycle.
  always_comb begin
    // NOTE: assign a default before any branch so every path drives state_next; otherwise a latch is inferred.
    state_next = state;
    if (rdy) begin
      case (state)
        NORMAL:  if (flush)  state_next = DRAIN;
        DRAIN:   if (!flush) state_next = NORMAL;
        default: state_next = NORMAL;
      endcase
    end
  end

  // State register: reset wins regardless of rdy.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (rst) state <= NORMAL;
    else     state <= state_next;
  end

  // Pointers and occupancy: freeze when not ready, clear on flush, otherwise track push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy) begin
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + PTR_ONE;
        if (pop)  head <= head + PTR_ONE;
        case ({push, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

  // Sticky overflow: a fetch presented into a full queue is lost; only reset clears the flag.
  always_ff @(posedge clk) begin
    if (rst) overflow <= 1'b0;
    else if (rdy && IF_success && full && (state == NORMAL) && !flush) overflow <= 1'b1;
  end

  // Entry storage: written at the tail on an accepted push.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the valid range is defined by head/count, so stale words are never issued.
    if (push && !rst) begin
      instr_mem[tail] <= instr;
      pc_mem[tail]    <= pc;
    end
  end

endmodule
